priority_scan_encoder: RTL

- Parametrised, sequential successor to the team's fixed 4-bit priority encoder.
- Accepts a WIDTH-bit request vector over a valid/ready handshake and stores it.
- Emits the index of every set bit, one per beat, in priority order, clearing each bit as it is consumed.
- Sits between request-collecting logic and any consumer that services one request index at a time.

---
 rtl/priority_scan_encoder.sv | 118 +++++++++++
 1 files changed

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: stores a request vector and emits the index of each set bit,
// one beat per handshake, in priority order. Optional macro: PRIORITY_SCAN_ZERO_REPORT_EN.
//
// state | meaning
// IDLE  | ready for a new vector (after the first post-reset edge)
// SCAN  | emitting one beat per pending bit
// ZERO  | single all-zero report beat (macro builds only)
module priority_scan_encoder #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 1,
   localparam int IDX_W    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i,
   input  logic             i_valid,
   output logic             i_ready,
   output logic [IDX_W-1:0] y,
   output logic             y_valid,
   input  logic             y_ready,
   output logic             y_last,
   output logic             zero
);

`ifdef PRIORITY_SCAN_ZERO_REPORT_EN
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, ZERO = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1} state_t;
`endif

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   pending_q, pending_d;
   logic               live_q, live_d;
   logic [IDX_W-1:0]   sel_idx;
   logic [WIDTH-1:0]   sel_mask;
   logic [WIDTH-1:0]   rest;
   logic               last_beat;

   // Later loop iterations override earlier ones, so the scan order sets the priority.
   always_comb begin
      sel_idx = '0;
      if (MSB_FIRST != 0) begin
         for (int k = 0; k < WIDTH; k++) begin
            if (pending_q[k]) sel_idx = IDX_W'(k);
         end
      end else begin
         for (int k = WIDTH - 1; k >= 0; k--) begin
            if (pending_q[k]) sel_idx = IDX_W'(k);
         end
      end
   end

   assign sel_mask  = WIDTH'(1) << sel_idx;
   assign rest      = pending_q & ~sel_mask;
   assign last_beat = (rest == '0);

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      live_d    = 1'b1;
      i_ready   = 1'b0;
      y_valid   = 1'b0;
      y         = '0;
      y_last    = 1'b0;
      zero      = 1'b0;
      case (state_q)
         IDLE: begin
            i_ready = live_q;
            if (i_valid && live_q) begin
               pending_d = i;
               if (i != '0) begin
                  state_d = SCAN;
               end
`ifdef PRIORITY_SCAN_ZERO_REPORT_EN
               else begin
                  state_d = ZERO;
               end
`endif
            end
         end
         SCAN: begin
            y_valid = 1'b1;
            y       = sel_idx;
            y_last  = last_beat;
            if (y_ready) begin
               pending_d = rest;
               if (last_beat) state_d = IDLE;
            end
         end
`ifdef PRIORITY_SCAN_ZERO_REPORT_EN
         ZERO: begin
            y_valid = 1'b1;
            y_last  = 1'b1;
            zero    = 1'b1;
            if (y_ready) state_d = IDLE;
         end
`endif
         default: begin
            state_d   = IDLE;
            pending_d = '0;
         end
      endcase
   end

   // live_q holds i_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         live_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         live_q    <= live_d;
      end
   end

endmodule
